// File: rtl/core_pkg.sv
// ============================================================================
//  Module      : core_pkg
//  Description : Shared types and widths for the memory-side arbiter
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef ADR_WIDTH
`define ADR_WIDTH 32
`endif
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif

package core_pkg;

  localparam int ADR_WIDTH = `ADR_WIDTH;
  localparam int CPU_WIDTH = `CPU_WIDTH;

  // Owner encoding used by the last-owner register and o_owner
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  // Downstream request payload captured on the grant edge
  typedef struct packed {
    logic                 reqtyp;
    logic [ADR_WIDTH-1:0] addr;
    logic [CPU_WIDTH-1:0] wdata;
    logic [1:0]           size;
  } arb_payload_t;

  localparam int PAYLOAD_W = $bits(arb_payload_t);

endpackage

`default_nettype wire

// File: rtl/stl_reg.sv
// ============================================================================
//  Module      : stl_reg
//  Description : Enabled register with synchronous active-high reset
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module stl_reg #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Load on enable, return to the reset value when reset is sampled high
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_q <= RST_VAL;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arb.sv
// ============================================================================
//  Module      : mem_arb
//  Description : Two-port (fetch / load-store) round-robin arbiter in front of
//                a single memory port. Payload is registered at grant so the
//                downstream side never sees requester-side changes.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arb
  import core_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  // fetch requester
  input  logic                 i_i_valid,
  output logic                 o_i_ready,
  input  logic                 i_i_reqtyp,
  input  logic [ADR_WIDTH-1:0] i_i_addr,
  input  logic [CPU_WIDTH-1:0] i_i_wdata,
  input  logic [1:0]           i_i_size,
  output logic [CPU_WIDTH-1:0] o_i_rdata,
  // load/store requester
  input  logic                 i_d_valid,
  output logic                 o_d_ready,
  input  logic                 i_d_reqtyp,
  input  logic [ADR_WIDTH-1:0] i_d_addr,
  input  logic [CPU_WIDTH-1:0] i_d_wdata,
  input  logic [1:0]           i_d_size,
  output logic [CPU_WIDTH-1:0] o_d_rdata,
  // downstream memory port
  output logic                 o_mem_valid,
  input  logic                 i_mem_ready,
  output logic                 o_mem_reqtyp,
  output logic [ADR_WIDTH-1:0] o_mem_addr,
  output logic [CPU_WIDTH-1:0] o_mem_wdata,
  output logic [1:0]           o_mem_size,
  input  logic [CPU_WIDTH-1:0] i_mem_rdata,
  // status
  output logic                 o_busy,
  output logic                 o_owner
);

  arb_state_t   r_state;
  arb_state_t   w_state_nxt;
  logic         w_grant;
  logic         w_done;
  logic         r_last_owner;
  arb_payload_t r_payload;
  arb_payload_t w_payload_nxt;

  // State register; reset abandons any transaction in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: grant only from IDLE, so consecutive grants are separated by
  // one IDLE cycle; on contention the port that did not win last time goes
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_i_valid && i_d_valid) begin
          w_state_nxt = (r_last_owner == OWNER_I) ? GNT_D : GNT_I;
        end else if (i_d_valid) begin
          w_state_nxt = GNT_D;
        end else if (i_i_valid) begin
          w_state_nxt = GNT_I;
        end
        w_grant = (w_state_nxt != IDLE);
      end
      GNT_I, GNT_D: begin
        if (i_mem_ready) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Select the winner's request fields for capture on the grant edge
  always_comb begin
    w_payload_nxt = '0;
    if (w_state_nxt == GNT_D) begin
      w_payload_nxt.reqtyp = i_d_reqtyp;
      w_payload_nxt.addr   = i_d_addr;
      w_payload_nxt.wdata  = i_d_wdata;
      w_payload_nxt.size   = i_d_size;
    end else begin
      w_payload_nxt.reqtyp = i_i_reqtyp;
      w_payload_nxt.addr   = i_i_addr;
      w_payload_nxt.wdata  = i_i_wdata;
      w_payload_nxt.size   = i_i_size;
    end
  end

  stl_reg #(
    .WIDTH   (PAYLOAD_W),
    .RST_VAL ({PAYLOAD_W{1'b0}})
  ) u_payload_reg (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_grant),
    .i_d   (w_payload_nxt),
    .o_q   (r_payload)
  );

  // Last owner is only updated when a transaction actually completes
  stl_reg #(
    .WIDTH   (1),
    .RST_VAL (OWNER_I)
  ) u_last_owner_reg (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_done),
    .i_d   (r_state == GNT_D),
    .o_q   (r_last_owner)
  );

  assign o_mem_valid  = (r_state == GNT_I) || (r_state == GNT_D);
  assign o_busy       = (r_state != IDLE);
  assign o_mem_reqtyp = r_payload.reqtyp;
  assign o_mem_addr   = r_payload.addr;
  assign o_mem_wdata  = r_payload.wdata;
  assign o_mem_size   = r_payload.size;

  // A requester that withdrew its valid gets no ready: completion is dropped
  assign o_i_ready = i_mem_ready && (r_state == GNT_I) && i_i_valid;
  assign o_d_ready = i_mem_ready && (r_state == GNT_D) && i_d_valid;

  assign o_i_rdata = i_mem_rdata;
  assign o_d_rdata = i_mem_rdata;

  assign o_owner = (r_state == GNT_I) ? OWNER_I :
                   (r_state == GNT_D) ? OWNER_D : r_last_owner;

endmodule

`default_nettype wire

// File: tb/tb_mem_arb.sv
// ============================================================================
//  Module      : tb_mem_arb
//  Description : Self-checking bench for mem_arb (transaction model + directed)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arb;
  localparam int AW = core_pkg::ADR_WIDTH;
  localparam int DW = core_pkg::CPU_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 0, i_reqtyp = 0, d_valid = 0, d_reqtyp = 0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] i_wdata = '0, d_wdata = '0, mem_rdata = '0;
  logic [1:0]    i_size = '0, d_size = '0;
  logic          mem_ready = 0;

  logic          i_ready, d_ready, mem_valid, mem_reqtyp, busy, owner;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_size;

  int checks = 0;
  int errors = 0;
  logic run_chk = 1'b0;

  mem_arb dut (
    .i_clk(clk), .i_rst(rst),
    .i_i_valid(i_valid), .o_i_ready(i_ready), .i_i_reqtyp(i_reqtyp),
    .i_i_addr(i_addr), .i_i_wdata(i_wdata), .i_i_size(i_size), .o_i_rdata(i_rdata),
    .i_d_valid(d_valid), .o_d_ready(d_ready), .i_d_reqtyp(d_reqtyp),
    .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_size(d_size), .o_d_rdata(d_rdata),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_reqtyp(mem_reqtyp),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_size(mem_size),
    .i_mem_rdata(mem_rdata), .o_busy(busy), .o_owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: is a transfer outstanding, who owns it, what
  // was captured, and who finished last
  logic          m_act = 0, m_who = 0, m_last = 0;
  logic          m_typ = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [1:0]    m_size = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_act = 0; m_who = 0; m_last = 0;
      m_typ = 0; m_addr = '0; m_wdata = '0; m_size = '0;
    end else if (m_act) begin
      if (mem_ready) begin
        m_act  = 0;
        m_last = m_who;
      end
    end else if (i_valid || d_valid) begin
      m_who = (i_valid && d_valid) ? !m_last : d_valid;
      m_act = 1;
      if (m_who) begin
        m_typ = d_reqtyp; m_addr = d_addr; m_wdata = d_wdata; m_size = d_size;
      end else begin
        m_typ = i_reqtyp; m_addr = i_addr; m_wdata = i_wdata; m_size = i_size;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (run_chk) begin
      chk("mem_valid", mem_valid, m_act);
      chk("busy", busy, m_act);
      chk("owner", owner, m_act ? m_who : m_last);
      chk("i_ready", i_ready, m_act && !m_who && mem_ready && i_valid);
      chk("d_ready", d_ready, m_act && m_who && mem_ready && d_valid);
      chk("mem_reqtyp", mem_reqtyp, m_typ);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_size", mem_size, m_size);
      chk("i_rdata", i_rdata, mem_rdata);
      chk("d_rdata", d_rdata, mem_rdata);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ni, nd;
    // Reset
    tick();
    run_chk = 1'b1;
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_valid", mem_valid, 1'b0);
    chk("rst_addr", mem_addr, '0);
    rst = 1'b0;

    // Single d load, ready three cycles after grant
    d_valid = 1; d_reqtyp = 0; d_addr = 32'h8000_0010; d_size = 2'd3;
    #1;
    chk("A_valid_lat0", mem_valid, 1'b0);
    tick();
    chk("A_valid", mem_valid, 1'b1);
    chk("A_addr", mem_addr, 32'h8000_0010);
    chk("A_owner", owner, 1'b1);
    tick();
    tick();
    mem_ready = 1; mem_rdata = 64'h1122_3344_5566_7788;
    #1;
    chk("A_ready", d_ready, 1'b1);
    chk("A_rdata", d_rdata, 64'h1122_3344_5566_7788);
    tick();
    mem_ready = 0; d_valid = 0;
    #1;
    chk("A_idle", busy, 1'b0);

    // Simultaneous request after reset: d first, then i
    rst = 1;
    tick();
    rst = 0;
    i_valid = 1; i_addr = 32'h0000_1000; d_valid = 1; d_addr = 32'h8000_2000;
    tick();
    chk("B_owner_d", owner, 1'b1);
    chk("B_addr_d", mem_addr, 32'h8000_2000);
    mem_ready = 1;
    #1;
    chk("B_d_ready", d_ready, 1'b1);
    chk("B_i_ready0", i_ready, 1'b0);
    tick();
    mem_ready = 0; d_valid = 0;
    #1;
    chk("B_gap", mem_valid, 1'b0);
    tick();
    chk("B_owner_i", owner, 1'b0);
    chk("B_addr_i", mem_addr, 32'h0000_1000);
    mem_ready = 1;
    #1;
    chk("B_i_ready", i_ready, 1'b1);
    tick();
    mem_ready = 0; i_valid = 0;

    // Both continuously requesting, ready every other cycle
    i_valid = 1; i_addr = 32'h100; d_valid = 1; d_addr = 32'h200;
    ni = 0; nd = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      mem_ready = cyc[0];
      #1;
      if (cyc[0]) begin
        chk("C_owner", owner, ((cyc / 2) % 2 == 0) ? 1'b1 : 1'b0);
        if (i_ready) ni++;
        if (d_ready) nd++;
      end else begin
        chk("C_gap", mem_valid, 1'b0);
      end
      tick();
    end
    i_valid = 0; d_valid = 0; mem_ready = 0;
    chk("C_i_count", ni, 4);
    chk("C_d_count", nd, 4);

    // d store: address change and valid drop while granted
    d_valid = 1; d_reqtyp = 1; d_addr = 32'h8000_0100;
    d_wdata = 64'hCAFE_BABE_0BAD_F00D; d_size = 2'd2;
    tick();
    d_addr = 32'h1234_5678;
    #1;
    chk("D_addr_hold", mem_addr, 32'h8000_0100);
    tick();
    d_valid = 0;
    #1;
    chk("D_valid_held", mem_valid, 1'b1);
    chk("D_reqtyp", mem_reqtyp, 1'b1);
    chk("D_wdata", mem_wdata, 64'hCAFE_BABE_0BAD_F00D);
    tick();
    mem_ready = 1;
    #1;
    chk("D_no_ready", d_ready, 1'b0);
    tick();
    mem_ready = 0;
    #1;
    chk("D_idle", busy, 1'b0);
    d_valid = 1; d_reqtyp = 0; d_addr = 32'h8000_0200;
    tick();
    chk("D_new_addr", mem_addr, 32'h8000_0200);
    mem_ready = 1;
    #1;
    chk("D_new_ready", d_ready, 1'b1);
    tick();
    mem_ready = 0; d_valid = 0;

    // Reset during a pending i transaction
    i_valid = 1; i_addr = 32'h0000_3000;
    tick();
    chk("E_owner_i", owner, 1'b0);
    chk("E_busy", busy, 1'b1);
    tick();
    rst = 1;
    #1;
    chk("E_rst_i_ready", i_ready, 1'b0);
    tick();
    rst = 0; d_valid = 1; d_addr = 32'h8000_4000;
    #1;
    chk("E_valid0", mem_valid, 1'b0);
    chk("E_i_ready0", i_ready, 1'b0);
    chk("E_addr0", mem_addr, '0);
    tick();
    chk("E_owner_d", owner, 1'b1);
    mem_ready = 1;
    #1;
    chk("E_d_ready", d_ready, 1'b1);
    chk("E_i_ready_end", i_ready, 1'b0);
    tick();
    mem_ready = 0; d_valid = 0; i_valid = 0;
    tick();
    tick();
    run_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have ports, clock and reset first: i_clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have i_rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have per requester port p in {i (fetch), d (load/store)}: i_<p>_valid in 1, o_<p>_ready out 1, i_<p>_reqtyp in 1 (1=store), i_<p>_addr in ADR_WIDTH, i_<p>_wdata in CPU_WIDTH, i_<p>_size in 2, o_<p>_rdata out CPU_WIDTH.
REQ-004 SHALL have downstream port: o_mem_valid out 1, i_mem_ready in 1, o_mem_reqtyp out 1, o_mem_addr out ADR_WIDTH, o_mem_wdata out CPU_WIDTH, o_mem_size out 2, i_mem_rdata in CPU_WIDTH.
REQ-005 SHALL have o_busy out 1 (state != IDLE) and o_owner out 1 (0=i, 1=d; owner of current or last grant).

Function
REQ-006 SHALL implement FSM states IDLE, GNT_I, GNT_D.
REQ-007 In IDLE with only i_i_valid: next state GNT_I; only i_d_valid: GNT_D; neither: stay IDLE.
REQ-008 In IDLE with both valid: grant the port NOT granted last (round-robin via last-owner register); first contention after reset goes to d.
REQ-009 On grant edge, SHALL latch winner's reqtyp/addr/wdata/size into a payload register; downstream outputs driven only from this register.
REQ-010 o_mem_valid SHALL be 1 exactly while in GNT_I or GNT_D; held until i_mem_ready; payload stable throughout.
REQ-011 Arbitration latency: 1 cycle (request seen in IDLE at cycle N -> o_mem_valid at N+1); no combinational path from i_<p>_valid to o_mem_valid.
REQ-012 In GNT_x with i_mem_ready=1: next state IDLE, last-owner <= x; at least one IDLE cycle between grants.
REQ-013 o_x_ready SHALL equal i_mem_ready & (state==GNT_x) & i_x_valid; other port's ready SHALL be 0.
REQ-014 Requester dropping valid while granted (exception/interrupt/flush): downstream transaction SHALL still complete; completion is silently discarded, no ready pulse to that port.
REQ-015 Re-assertion of valid by an aborted requester SHALL be treated as a new request in IDLE.
REQ-016 o_<p>_rdata SHALL pass i_mem_rdata unmodified to both ports; meaningful only in the ready cycle.
REQ-017 A request held by the losing port SHALL be granted at the next IDLE cycle; max wait one full transaction of the other port.
REQ-018 SHALL not alter sign/size of data; size and address passed verbatim.

Reset
REQ-019 With i_rst=1 at an edge: state<=IDLE, last-owner<=i, payload<=0.
REQ-020 During/after reset until first grant: o_mem_valid=0, o_i_ready=0, o_d_ready=0, o_busy=0, o_owner=0, o_mem_* payload=0.
REQ-021 Reset asserted mid-transaction SHALL abandon it immediately; no ready issued.

Structure
REQ-022 State enum type (arb_state_t) SHALL live in shared package core_pkg; ADR_WIDTH/CPU_WIDTH from existing global defines.
REQ-023 Payload and last-owner registers SHALL use the team register primitive stl_reg; no other sub-module.

Verification
REQ-024 Single d load addr 0x8000_0010, mem ready after 3 cycles, rdata 0x1122334455667788 -> o_mem_valid at cycle+1, o_d_ready one cycle, rdata passed, back to IDLE.
REQ-025 i and d valid in same cycle after reset -> d granted first, i granted on cycle after d completes; o_owner 1 then 0.
REQ-026 Both continuously requesting, ready each other cycle -> strict alternation d,i,d,i over 8 transactions, none starved.
REQ-027 d store 0x8000_0100 granted, d valid dropped before ready -> o_mem_valid held with unchanged payload until ready; o_d_ready stays 0; FSM returns IDLE.
REQ-028 i_rst pulsed while in GNT_I with ready pending -> next cycle IDLE, o_mem_valid=0, o_i_ready never 1, next contention grants d.
REQ-029 Requester changes addr while granted -> o_mem_addr keeps latched value.
